uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving payload bits per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake.
REQ-006 SHALL have port tx_valid  input  1  requester has a byte on tx_data.
REQ-007 SHALL have port tx_ready  output  1  engine idle and able to accept a byte.
REQ-008 SHALL have port tx  output  1  serial line, idle high; registered output, no glitches.
REQ-009 SHALL have port tx_busy  output  1  frame in progress (start, data or stop bit on line).
REQ-010 SHALL have port tx_done  output  1  single-cycle pulse marking end of a frame.

Function
REQ-011 Frame format SHALL be 8N1-style: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), no parity.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 tx_ready SHALL equal (state == IDLE); tx_busy SHALL equal (state != IDLE).
REQ-014 Handshake SHALL occur on a rising edge where tx_valid && tx_ready && !rst; tx_data is then latched into an internal shift register; later changes to tx_data SHALL have no effect on the frame.
REQ-015 On handshake the FSM SHALL go IDLE->START, and tx SHALL be 0 from the following cycle (latency 1 clock).
REQ-016 A baud counter, width ceil(log2(CLKS_PER_BIT)), SHALL clear on entry to START and count 0..CLKS_PER_BIT-1, wrapping to 0; the wrap cycle is the bit-end tick.
REQ-017 Each bit SHALL be held on tx for exactly CLKS_PER_BIT cycles; a full frame SHALL occupy (DATA_BITS+2)*CLKS_PER_BIT cycles (4340 at defaults).
REQ-018 START->DATA SHALL occur on the bit-end tick; in DATA the shift register shifts right one place per tick, and a bit index (0..DATA_BITS-1) increments per tick.
REQ-019 DATA->STOP SHALL occur on the bit-end tick with bit index == DATA_BITS-1; STOP->IDLE on the next bit-end tick.
REQ-020 tx_done SHALL be asserted for exactly one cycle, the last cycle of the stop bit; tx_ready SHALL rise on the following cycle.
REQ-021 tx_valid asserted outside IDLE SHALL be ignored (no queuing); requester holds it until tx_ready.
REQ-022 With tx_valid held high continuously, consecutive frames SHALL be separated by exactly one idle-high cycle (the IDLE handshake cycle).
REQ-023 tx_data value and tx_valid toggling mid-frame SHALL not disturb tx.

Reset
REQ-024 While rst is high at a rising edge: state=IDLE, tx=1, tx_done=0, baud counter=0, bit index=0, shift register=0.
REQ-025 Consequently, on the first cycle after a reset edge, tx_ready=1 and tx_busy=0; no handshake is accepted in a cycle where rst is high.
REQ-026 Reset mid-frame SHALL abandon the frame: tx=1 on the next cycle, no tx_done pulse.

Structure
REQ-027 Shared package uart_pkg SHALL hold the CLKS_PER_BIT default, DATA_BITS default and the tx state enum type.
REQ-028 The baud counter SHALL be a sub-module uart_tx_baud_gen (inputs clk, rst, clear; output bit_tick); the remainder is FSM and shift register in uart_tx_engine.

Verification
REQ-029 Reset: hold rst 3 cycles, release -> tx=1, tx_ready=1, tx_busy=0, tx_done=0 immediately after.
REQ-030 Single byte 0x55 at defaults -> tx low 1 cycle after handshake; line sampled at bit centres reads 0,1,0,1,0,1,0,1,0,1; every bit 434 cycles; tx_done at cycle 4340 after handshake; tx_ready 1 cycle later.
REQ-031 Back-to-back 0xA3 then 0x0F with tx_valid held -> two frames decode correctly, exactly one idle-high cycle between stop bit and second start bit.
REQ-032 Change tx_data from 0xFF to 0x00 and toggle tx_valid mid-frame -> frame still decodes 0xFF; no second frame starts until tx_ready.
REQ-033 Assert rst during bit 4 of a 0x00 frame -> tx=1 next cycle, no tx_done pulse, tx_ready=1 after release, fresh frame 0x81 then sends correctly.
REQ-034 CLKS_PER_BIT=2, byte 0x01 -> frame lasts 20 cycles, each bit 2 cycles, tx_done on cycle 20.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults and state type for the UART transmit path.
package uart_pkg;

    // 50 MHz clock at 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned DATA_BITS_DEFAULT    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
module uart_tx_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    // One cycle before bit_tick; used so the engine can register its end-of-frame pulse
    output logic bit_pre_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: hold at zero while cleared, wrap after the last cycle of a bit
    always_comb begin
        bit_tick     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        bit_pre_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
        cnt_d        = cnt_q + CNT_W'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_e            state_q;
    logic                 tx_q;
    logic                 done_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 bit_tick;
    logic                 bit_pre_tick;

    // Counter held at zero while idle, so it starts from zero on entry to StStart
    uart_tx_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_q == StIdle),
        .bit_tick     (bit_tick),
        .bit_pre_tick (bit_pre_tick)
    );

    // Frame sequencer with registered line and done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_valid) begin
                        state_q <= StStart;
                        shift_q <= tx_data;
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_tick) begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        idx_q   <= '0;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end
                end
                StStop: begin
                    // Pulse lands on the last cycle of the stop bit
                    if (bit_pre_tick) begin
                        done_q <= 1'b1;
                    end
                    if (bit_tick) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx       = tx_q;
    assign tx_done  = done_q;
    assign tx_ready = (state_q == StIdle);
    assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench: two engines (default baud and CLKS_PER_BIT=2) checked sample-by-sample
// against a line waveform built from the frame format.
module tb_uart_tx_engine;

    localparam int A_CPB = 434;
    localparam int B_CPB = 2;
    localparam int NA    = 10 * A_CPB;
    localparam int NB    = 10 * B_CPB;

    logic       clk;
    logic       rst_a, valid_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       rst_b, valid_b, ready_b, tx_b, busy_b, done_b;
    logic [7:0] data_b;

    int vectors    = 0;
    int miscompares = 0;
    int prints     = 0;

    // Expected line behaviour and captured DUT samples, one entry per clock
    bit   e_tx[$], e_done[$], e_ready[$];
    logic q_tx[$], q_done[$], q_ready[$], q_busy[$];

    uart_tx_engine u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .tx_data  (data_a),
        .tx_valid (valid_a),
        .tx_ready (ready_a),
        .tx       (tx_a),
        .tx_busy  (busy_a),
        .tx_done  (done_a)
    );

    uart_tx_engine #(
        .CLKS_PER_BIT (B_CPB),
        .DATA_BITS    (8)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .tx_data  (data_b),
        .tx_valid (valid_b),
        .tx_ready (ready_b),
        .tx       (tx_b),
        .tx_busy  (busy_b),
        .tx_done  (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_logs();
        e_tx.delete(); e_done.delete(); e_ready.delete();
        q_tx.delete(); q_done.delete(); q_ready.delete(); q_busy.delete();
    endtask

    // A frame is 10 bit slots: start(0), data LSB first, stop(1); each slot cpb clocks long
    task automatic push_frame(input logic [7:0] d, input int cpb);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < cpb; c++) begin
                e_tx.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : d[k-1]));
                e_done.push_back(k == 9 && c == cpb - 1);
                e_ready.push_back(1'b0);
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            e_tx.push_back(1'b1);
            e_done.push_back(1'b0);
            e_ready.push_back(1'b1);
        end
    endtask

    task automatic sample(input bit sel);
        @(negedge clk);
        if (sel) begin
            q_tx.push_back(tx_b); q_done.push_back(done_b);
            q_ready.push_back(ready_b); q_busy.push_back(busy_b);
        end else begin
            q_tx.push_back(tx_a); q_done.push_back(done_a);
            q_ready.push_back(ready_a); q_busy.push_back(busy_a);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b1; valid_b = 1'b1;
        data_a = 8'h00; data_b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b} !== 8'b1100_1100) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: a/b tx,ready,busy,done got %b%b%b%b %b%b%b%b want 1100 1100",
                         i, tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b} !== 8'b1100_1100) begin
            miscompares++;
            $display("FAIL reset_release: a/b tx,ready,busy,done got %b%b%b%b %b%b%b%b want 1100 1100",
                     tx_a, ready_a, busy_a, done_a, tx_b, ready_b, busy_b, done_b);
        end
    endtask

    task automatic test_single_byte();
        clear_logs();
        push_frame(8'h55, A_CPB);
        push_idle(2);
        valid_a = 1'b1; data_a = 8'h55;
        for (int i = 0; i < e_tx.size(); i++) begin
            sample(1'b0);
            if (i == 0) valid_a = 1'b0;
        end
        for (int i = 0; i < e_tx.size(); i++) begin
            vectors++;
            if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL single_0x55 sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b", i,
                             q_tx[i], q_done[i], q_ready[i], q_busy[i], e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        push_frame(8'hA3, A_CPB);
        push_idle(1);
        push_frame(8'h0F, A_CPB);
        push_idle(2);
        valid_a = 1'b1; data_a = 8'hA3;
        for (int i = 0; i < e_tx.size(); i++) begin
            sample(1'b0);
            if (i == 0) data_a = 8'h0F;
            if (i == NA + 1) valid_a = 1'b0;
        end
        for (int i = 0; i < e_tx.size(); i++) begin
            vectors++;
            if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL back_to_back sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b", i,
                             q_tx[i], q_done[i], q_ready[i], q_busy[i], e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                end
            end
        end
    endtask

    task automatic test_input_churn();
        clear_logs();
        push_frame(8'hFF, A_CPB);
        push_idle(3);
        valid_a = 1'b1; data_a = 8'hFF;
        for (int i = 0; i < e_tx.size(); i++) begin
            sample(1'b0);
            data_a  = 8'h00;
            valid_a = (i < NA - 1) ? ~i[0] : 1'b0;
        end
        for (int i = 0; i < e_tx.size(); i++) begin
            vectors++;
            if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL input_churn sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b", i,
                             q_tx[i], q_done[i], q_ready[i], q_busy[i], e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        // Reset lands inside data bit 4 (frame slot 5)
        int i_r;
        i_r = 5 * A_CPB + 200;
        clear_logs();
        push_frame(8'h00, A_CPB);
        while (e_tx.size() > i_r + 1) begin
            void'(e_tx.pop_back()); void'(e_done.pop_back()); void'(e_ready.pop_back());
        end
        push_idle(6);
        push_frame(8'h81, A_CPB);
        push_idle(2);
        valid_a = 1'b1; data_a = 8'h00;
        for (int i = 0; i < e_tx.size(); i++) begin
            sample(1'b0);
            if (i == 0) valid_a = 1'b0;
            if (i == i_r) rst_a = 1'b1;
            if (i == i_r + 3) rst_a = 1'b0;
            if (i == i_r + 6) begin valid_a = 1'b1; data_a = 8'h81; end
            if (i == i_r + 7) valid_a = 1'b0;
        end
        for (int i = 0; i < e_tx.size(); i++) begin
            vectors++;
            if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL reset_mid_frame sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b", i,
                             q_tx[i], q_done[i], q_ready[i], q_busy[i], e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                end
            end
        end
    endtask

    task automatic test_min_baud();
        clear_logs();
        push_frame(8'h01, B_CPB);
        push_idle(2);
        valid_b = 1'b1; data_b = 8'h01;
        for (int i = 0; i < e_tx.size(); i++) begin
            sample(1'b1);
            if (i == 0) valid_b = 1'b0;
        end
        for (int i = 0; i < e_tx.size(); i++) begin
            vectors++;
            if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL min_baud sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b", i,
                             q_tx[i], q_done[i], q_ready[i], q_busy[i], e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                end
            end
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        int         gap;
        for (int f = 0; f < 40; f++) begin
            d   = 8'($urandom);
            gap = $urandom_range(1, 4);
            clear_logs();
            push_frame(d, B_CPB);
            push_idle(gap);
            valid_b = 1'b1; data_b = d;
            for (int i = 0; i < e_tx.size(); i++) begin
                sample(1'b1);
                // Busy-time churn on the inputs must be ignored
                if (i < NB - 1) begin
                    valid_b = 1'($urandom);
                    data_b  = 8'($urandom);
                end else begin
                    valid_b = 1'b0;
                end
            end
            for (int i = 0; i < e_tx.size(); i++) begin
                vectors++;
                if ({q_tx[i], q_done[i], q_ready[i], q_busy[i]} !== {e_tx[i], e_done[i], e_ready[i], !e_ready[i]}) begin
                    miscompares++;
                    if (prints < 40) begin
                        prints++;
                        $display("FAIL random_frame %0d (0x%02h) sample %0d: tx,done,ready,busy got %b%b%b%b want %b%b%b%b",
                                 f, d, i, q_tx[i], q_done[i], q_ready[i], q_busy[i],
                                 e_tx[i], e_done[i], e_ready[i], !e_ready[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_input_churn();
        test_reset_mid_frame();
        test_min_baud();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
